// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - draws unique cards from a multi-suit deck using a free-running LFSR start point
// Probes one bitmap slot per cycle from a random start, wrapping, until an undealt card is found.
module card_dealer #(
    parameter int RANKS  = 13,
    parameter int SUITS  = 4,
    parameter int LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED = LFSR_W'(16'hACE1),
    localparam int N     = RANKS * SUITS,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             draw_i,
    input  logic             shuffle_i,
    output logic             card_valid_o,
    output logic [3:0]       rank_o,
    output logic [1:0]       suit_o,
    output logic [CNT_W-1:0] cards_left_o,
    output logic             empty_o,
    output logic             busy_o,
    output logic             draw_err_o
);

    typedef enum logic {IDLE, SEARCH} state_t;

    function automatic logic [LFSR_W-1:0] tp(input int t);
        return LFSR_W'(1) << (LFSR_W - t);
    endfunction

    // Fibonacci tap positions, right-shifting form: tap t feeds from bit LFSR_W-t.
    function automatic logic [LFSR_W-1:0] tap_mask();
        case (LFSR_W)
            8:       return tp(8) | tp(6) | tp(5) | tp(4);
            9:       return tp(9) | tp(5);
            10:      return tp(10) | tp(7);
            11:      return tp(11) | tp(9);
            12:      return tp(12) | tp(6) | tp(4) | tp(1);
            13:      return tp(13) | tp(4) | tp(3) | tp(1);
            14:      return tp(14) | tp(5) | tp(3) | tp(1);
            15:      return tp(15) | tp(14);
            17:      return tp(17) | tp(14);
            18:      return tp(18) | tp(11);
            19:      return tp(19) | tp(6) | tp(2) | tp(1);
            20:      return tp(20) | tp(17);
            21:      return tp(21) | tp(19);
            22:      return tp(22) | tp(21);
            23:      return tp(23) | tp(18);
            24:      return tp(24) | tp(23) | tp(22) | tp(17);
            25:      return tp(25) | tp(22);
            26:      return tp(26) | tp(6) | tp(2) | tp(1);
            27:      return tp(27) | tp(5) | tp(2) | tp(1);
            28:      return tp(28) | tp(25);
            29:      return tp(29) | tp(27);
            30:      return tp(30) | tp(6) | tp(4) | tp(1);
            31:      return tp(31) | tp(28);
            32:      return tp(32) | tp(22) | tp(2) | tp(1);
            default: return tp(16) | tp(14) | tp(13) | tp(11);
        endcase
    endfunction

    localparam logic [LFSR_W-1:0] TAPS = tap_mask();

    state_t             state_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [LFSR_W-1:0]  lfsr_d;
    logic [N-1:0]       dealt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cards_left_q;
    logic [3:0]         rank_q;
    logic [1:0]         suit_q;
    logic               card_valid_q;
    logic               busy_q;
    logic               empty_q;
    logic               draw_err_q;

    always_comb begin
        lfsr_d = {^(lfsr_q & TAPS), lfsr_q[LFSR_W-1:1]};
        if (lfsr_d == '0) begin
            lfsr_d = SEED;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED;
            dealt_q      <= '0;
            idx_q        <= '0;
            cards_left_q <= CNT_W'(N);
            rank_q       <= '0;
            suit_q       <= '0;
            card_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            empty_q      <= 1'b0;
            draw_err_q   <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            card_valid_q <= 1'b0;
            draw_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (shuffle_i) begin
                        dealt_q      <= '0;
                        cards_left_q <= CNT_W'(N);
                        empty_q      <= 1'b0;
                        rank_q       <= '0;
                        suit_q       <= '0;
                    end else if (draw_i) begin
                        if (empty_q) begin
                            draw_err_q <= 1'b1;
                        end else begin
                            idx_q   <= IDX_W'(lfsr_q % LFSR_W'(N));
                            busy_q  <= 1'b1;
                            state_q <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    // A shuffle aborts the search; the card being probed is never dealt.
                    if (shuffle_i) begin
                        dealt_q      <= '0;
                        cards_left_q <= CNT_W'(N);
                        empty_q      <= 1'b0;
                        rank_q       <= '0;
                        suit_q       <= '0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end else if (!dealt_q[idx_q]) begin
                        dealt_q[idx_q] <= 1'b1;
                        rank_q         <= 4'((32'(idx_q) % RANKS) + 1);
                        suit_q         <= 2'(32'(idx_q) / RANKS);
                        cards_left_q   <= cards_left_q - CNT_W'(1);
                        empty_q        <= (cards_left_q == CNT_W'(1));
                        card_valid_q   <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end else begin
                        idx_q <= (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign card_valid_o = card_valid_q;
    assign rank_o       = rank_q;
    assign suit_o       = suit_q;
    assign cards_left_o = cards_left_q;
    assign empty_o      = empty_q;
    assign busy_o       = busy_q;
    assign draw_err_o   = draw_err_q;

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - directed self-checking bench for card_dealer (52-card and 2-card decks)
module tb_card_dealer;

    logic       clk;
    logic       rst;
    logic       draw, shuffle;
    logic       card_valid, empty, busy, draw_err;
    logic [3:0] rank;
    logic [1:0] suit;
    logic [5:0] cards_left;

    logic       draw_s, shuffle_s;
    logic       card_valid_s, empty_s, busy_s, draw_err_s;
    logic [3:0] rank_s;
    logic [1:0] suit_s;
    logic [1:0] cards_left_s;

    logic [15:0] m_lfsr;
    bit          bm [52];
    bit          seen [64];
    bit          bm_s [2];
    int          left;
    int          n_checks = 0;
    int          n_errs = 0;
    int          first_r, first_s, last_r, last_s;

    card_dealer u_dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .draw_i      (draw),
        .shuffle_i   (shuffle),
        .card_valid_o(card_valid),
        .rank_o      (rank),
        .suit_o      (suit),
        .cards_left_o(cards_left),
        .empty_o     (empty),
        .busy_o      (busy),
        .draw_err_o  (draw_err)
    );

    card_dealer #(.RANKS(2), .SUITS(1)) u_small (
        .clock_i     (clk),
        .reset_i     (rst),
        .draw_i      (draw_s),
        .shuffle_i   (shuffle_s),
        .card_valid_o(card_valid_s),
        .rank_o      (rank_s),
        .suit_o      (suit_s),
        .cards_left_o(cards_left_s),
        .empty_o     (empty_s),
        .busy_o      (busy_s),
        .draw_err_o  (draw_err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 52; i++) bm[i] = 0;
        for (int i = 0; i < 64; i++) seen[i] = 0;
        left = 52;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic draw_big(output int er, output int es);
        int start, i, k, lat;
        @(negedge clk);
        start = int'(m_lfsr % 16'd52);
        draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        lat = 1;
        while (card_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        i = start;
        k = 0;
        while (bm[i]) begin
            i = (i + 1) % 52;
            k++;
        end
        bm[i] = 1;
        left--;
        er = i % 13 + 1;
        es = i / 13;
        check_eq("valid", card_valid, 1);
        check_eq("rank", rank, er);
        check_eq("suit", suit, es);
        check_eq("latency", lat, 2 + k);
        check_eq("lat_range", (lat >= 2 && lat <= 53), 1);
        check_eq("left", cards_left, left);
        check_eq("distinct", seen[{suit, rank}], 0);
        seen[{suit, rank}] = 1;
        @(negedge clk);
        check_eq("pulse", card_valid, 0);
    endtask

    task automatic shuffle_big();
        @(negedge clk);
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        clear_model();
        check_eq("shuf_left", cards_left, 52);
        check_eq("shuf_rank", rank, 0);
        check_eq("shuf_empty", empty, 0);
    endtask

    task automatic draw_small(output int er);
        int start, i, k, lat;
        @(negedge clk);
        start = int'(m_lfsr % 16'd2);
        draw_s = 1'b1;
        @(negedge clk);
        draw_s = 1'b0;
        lat = 1;
        while (card_valid_s !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        i = start;
        k = 0;
        while (bm_s[i]) begin
            i = (i + 1) % 2;
            k++;
        end
        bm_s[i] = 1;
        er = i + 1;
        check_eq("s_valid", card_valid_s, 1);
        check_eq("s_rank", rank_s, er);
        check_eq("s_suit", suit_s, 0);
        check_eq("s_latency", lat, 2 + k);
    endtask

    initial begin
        int r, s, r1, r2;
        rst = 1'b1;
        draw = 1'b0;
        shuffle = 1'b0;
        draw_s = 1'b0;
        shuffle_s = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", card_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_left", cards_left, 52);
        check_eq("rst_rank", rank, 0);
        check_eq("rst_suit", suit, 0);
        check_eq("rst_empty", empty, 0);
        check_eq("rst_err", draw_err, 0);
        do_reset();

        // Full deck from reset.
        for (int n = 0; n < 52; n++) begin
            draw_big(r, s);
            if (n == 0) begin
                first_r = r;
                first_s = s;
            end
            last_r = r;
            last_s = s;
        end
        check_eq("full_empty", empty, 1);
        check_eq("full_left", cards_left, 0);

        // Draw while empty.
        @(negedge clk);
        draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        check_eq("err_pulse", draw_err, 1);
        check_eq("err_novalid", card_valid, 0);
        check_eq("err_busy", busy, 0);
        @(negedge clk);
        check_eq("err_fall", draw_err, 0);
        check_eq("err_novalid2", card_valid, 0);
        check_eq("err_rank", rank, last_r);
        check_eq("err_suit", suit, last_s);
        check_eq("err_left", cards_left, 0);

        // Two-card deck, several rounds.
        for (int round = 0; round < 6; round++) begin
            @(negedge clk);
            shuffle_s = 1'b1;
            @(negedge clk);
            shuffle_s = 1'b0;
            bm_s[0] = 0;
            bm_s[1] = 0;
            check_eq("s_shuf_left", cards_left_s, 2);
            draw_small(r1);
            draw_small(r2);
            check_eq("s_other", r2, 3 - r1);
            check_eq("s_empty", empty_s, 1);
            check_eq("s_left", cards_left_s, 0);
        end

        // Shuffle on the first SEARCH cycle aborts the draw.
        shuffle_big();
        for (int n = 0; n < 51; n++) draw_big(r, s);
        @(negedge clk);
        draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        shuffle = 1'b1;
        check_eq("abort_busy_in", busy, 1);
        @(negedge clk);
        shuffle = 1'b0;
        clear_model();
        check_eq("abort_valid", card_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_left", cards_left, 52);
        check_eq("abort_rank", rank, 0);
        check_eq("abort_empty", empty, 0);
        @(negedge clk);
        check_eq("abort_valid2", card_valid, 0);
        for (int n = 0; n < 52; n++) draw_big(r, s);
        check_eq("redeal_empty", empty, 1);

        // Draw and shuffle together in IDLE.
        shuffle_big();
        for (int n = 0; n < 12; n++) draw_big(r, s);
        check_eq("pre_left", cards_left, 40);
        @(negedge clk);
        draw = 1'b1;
        shuffle = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        shuffle = 1'b0;
        clear_model();
        check_eq("both_left", cards_left, 52);
        check_eq("both_busy", busy, 0);
        check_eq("both_valid", card_valid, 0);
        @(negedge clk);
        check_eq("both_busy2", busy, 0);
        check_eq("both_valid2", card_valid, 0);

        // Asynchronous reset in the middle of a search.
        @(negedge clk);
        draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        check_eq("ar_busy_in", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("ar_valid", card_valid, 0);
        check_eq("ar_busy", busy, 0);
        check_eq("ar_left", cards_left, 52);
        check_eq("ar_rank", rank, 0);
        check_eq("ar_suit", suit, 0);
        check_eq("ar_empty", empty, 0);
        do_reset();
        draw_big(r, s);
        check_eq("ar_first_rank", rank, first_r);
        check_eq("ar_first_suit", suit, first_s);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
